// File: rtl/exec_unit_ctrl.sv
// Sequencer for multi-cycle execution units (multiplier, FPU): issue, wait with watchdog, writeback.
// Optional build macro EXEC_CTRL_PERF_EN adds PerfOps/PerfStall performance counters.
module exec_unit_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       UnitSel,
   input  logic [2:0] OpIn,
   input  logic [1:0] FlagWIn,
   input  logic [3:0] RdIn,
   input  logic [3:0] RdHiIn,
   input  logic       Kill,
   input  logic       MulDone,
   input  logic       FpuDone,
   output logic       Stall,
   output logic       Busy,
   output logic       MulReq,
   output logic       FpuReq,
   output logic [2:0] UnitOp,
   output logic       Abort,
   output logic       RegWrEn,
   output logic [3:0] WrAddr,
   output logic       WrHi,
   output logic [1:0] FlagWEn,
   output logic       Timeout,
   output logic [2:0] dbg_state
`ifdef EXEC_CTRL_PERF_EN
   ,
   output logic [31:0] PerfOps,
   output logic [31:0] PerfStall
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_WB_LO = 3'd3,
      S_WB_HI = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_cnt_nxt;

   logic             lat_sel;
   logic [2:0]       lat_op;
   logic [1:0]       lat_fw;
   logic [3:0]       lat_rd;
   logic [3:0]       lat_rdhi;

   logic             accept;
   logic             sel_done;
   logic             long_mul;
   logic             wd_expire;

   // Handshake: Req is a one-cycle pulse in ISSUE; the unit answers with a one-cycle
   // Done pulse any number of cycles later (including the Req cycle itself). Only the
   // selected unit's Done is honoured. Abort tells the unit to drop the op in flight.
   always_comb begin
      accept    = (state == S_IDLE) && Start && !Kill;
      sel_done  = lat_sel ? FpuDone : MulDone;
      long_mul  = !lat_sel && ((lat_op == 3'b101) || (lat_op == 3'b110));
      wd_expire = (state == S_WAIT) && (wd_cnt == WD_LAST) && !sel_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wd_cnt   <= '0;
         lat_sel  <= 1'b0;
         lat_op   <= 3'b000;
         lat_fw   <= 2'b00;
         lat_rd   <= 4'h0;
         lat_rdhi <= 4'h0;
      end else begin
         state  <= state_nxt;
         wd_cnt <= wd_cnt_nxt;
         if (accept) begin
            lat_sel  <= UnitSel;
            lat_op   <= OpIn;
            lat_fw   <= FlagWIn;
            lat_rd   <= RdIn;
            lat_rdhi <= RdHiIn;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      wd_cnt_nxt = wd_cnt;
      MulReq     = 1'b0;
      FpuReq     = 1'b0;
      Abort      = 1'b0;
      Timeout    = 1'b0;
      RegWrEn    = 1'b0;
      WrAddr     = 4'h0;
      WrHi       = 1'b0;
      FlagWEn    = 2'b00;

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_ISSUE;
            end
         end

         S_ISSUE: begin
            MulReq     = !lat_sel;
            FpuReq     = lat_sel;
            wd_cnt_nxt = '0;
            // Kill wins over a Done arriving in the same cycle.
            if (Kill) begin
               Abort     = 1'b1;
               state_nxt = S_IDLE;
            end else if (sel_done) begin
               state_nxt = S_WB_LO;
            end else begin
               state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            Timeout = wd_expire;
            Abort   = Kill || wd_expire;
            if (Kill || wd_expire) begin
               state_nxt = S_IDLE;
            end else if (sel_done) begin
               state_nxt = S_WB_LO;
            end else begin
               wd_cnt_nxt = wd_cnt + CNT_W'(1);
            end
         end

         S_WB_LO: begin
            RegWrEn   = 1'b1;
            WrAddr    = lat_rd;
            FlagWEn   = lat_fw;
            state_nxt = long_mul ? S_WB_HI : S_IDLE;
         end

         S_WB_HI: begin
            RegWrEn   = 1'b1;
            WrAddr    = lat_rdhi;
            WrHi      = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Stall covers the Start cycle itself so the issuing instruction holds in decode.
   assign Busy      = (state != S_IDLE);
   assign Stall     = Busy | (Start & (state == S_IDLE));
   assign UnitOp    = lat_op;
   assign dbg_state = state;

`ifdef EXEC_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         PerfOps   <= 32'd0;
         PerfStall <= 32'd0;
      end else begin
         if ((state_nxt == S_WB_LO) && (state != S_WB_LO)) begin
            PerfOps <= PerfOps + 32'd1;
         end
         if (Stall) begin
            PerfStall <= PerfStall + 32'd1;
         end
      end
   end
`endif

   a_mulreq_pulse:  assert property (@(posedge clk) disable iff (reset) MulReq  |=> !MulReq);
   a_fpureq_pulse:  assert property (@(posedge clk) disable iff (reset) FpuReq  |=> !FpuReq);
   a_abort_pulse:   assert property (@(posedge clk) disable iff (reset) Abort   |=> !Abort);
   a_timeout_pulse: assert property (@(posedge clk) disable iff (reset) Timeout |=> !Timeout);

endmodule

// File: tb/tb_exec_unit_ctrl.sv
// Bench for exec_unit_ctrl: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_exec_unit_ctrl;

  localparam int T  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       Start = 1'b0;
  logic       UnitSel = 1'b0;
  logic [2:0] OpIn = 3'b000;
  logic [1:0] FlagWIn = 2'b00;
  logic [3:0] RdIn = 4'h0;
  logic [3:0] RdHiIn = 4'h0;
  logic       Kill = 1'b0;
  logic       MulDone = 1'b0;
  logic       FpuDone = 1'b0;

  logic       Stall, Busy, MulReq, FpuReq, Abort, RegWrEn, WrHi, Timeout;
  logic [2:0] UnitOp;
  logic [3:0] WrAddr;
  logic [1:0] FlagWEn;
  logic [2:0] dbg_state;
  logic [16:0] outs_v;

  exec_unit_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .UnitSel(UnitSel), .OpIn(OpIn),
    .FlagWIn(FlagWIn), .RdIn(RdIn), .RdHiIn(RdHiIn), .Kill(Kill),
    .MulDone(MulDone), .FpuDone(FpuDone), .Stall(Stall), .Busy(Busy),
    .MulReq(MulReq), .FpuReq(FpuReq), .UnitOp(UnitOp), .Abort(Abort),
    .RegWrEn(RegWrEn), .WrAddr(WrAddr), .WrHi(WrHi), .FlagWEn(FlagWEn),
    .Timeout(Timeout), .dbg_state(dbg_state)
  );

  assign outs_v = {Stall, Busy, MulReq, FpuReq, UnitOp, Abort, RegWrEn, WrAddr, WrHi, FlagWEn, Timeout};

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // ---------------- unit responder (stimulus only) ----------------
  int mul_lat = -1;
  int fpu_lat = -1;
  int mul_cnt = -1;
  int fpu_cnt = -1;
  bit spur_en = 1'b0;
  bit force_fpu = 1'b0;
  bit last_abort = 1'b0;

  always @(negedge clk) last_abort = (Abort === 1'b1) || reset;

  always @(posedge clk) begin
    #2;
    MulDone = 1'b0;
    FpuDone = 1'b0;
    if (last_abort) begin
      mul_cnt = -1;
      fpu_cnt = -1;
    end
    if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin MulDone = 1'b1; mul_cnt = -1; end
    end
    if (fpu_cnt > 0) begin
      fpu_cnt--;
      if (fpu_cnt == 0) begin FpuDone = 1'b1; fpu_cnt = -1; end
    end
    if (MulReq === 1'b1 && mul_lat >= 0) begin
      if (mul_lat == 0) MulDone = 1'b1; else mul_cnt = mul_lat;
    end
    if (FpuReq === 1'b1 && fpu_lat >= 0) begin
      if (fpu_lat == 0) FpuDone = 1'b1; else fpu_cnt = fpu_lat;
    end
    if (force_fpu) FpuDone = 1'b1;
    if (spur_en) begin
      if ($urandom_range(0, 15) == 0) MulDone = 1'b1;
      if ($urandom_range(0, 15) == 0) FpuDone = 1'b1;
    end
  end

  // ---------------- transaction-level model + scoreboard ----------------
  // An accepted op is "in flight" with an age (0 = request cycle). On completion its
  // register writes are queued as {addr, hi, flags}, one retired per cycle.
  logic [6:0] exp_q[$];
  bit         m_active = 1'b0;
  int         m_age = 0;
  bit         m_sel = 1'b0;
  logic [2:0] m_op = 3'b000;
  logic [1:0] m_fw = 2'b00;
  logic [3:0] m_rd = 4'h0;
  logic [3:0] m_rdhi = 4'h0;
  logic [2:0] m_unitop = 3'b000;

  always @(negedge clk) begin
    bit e_busy, e_stall, e_mreq, e_freq, e_abort, e_tmo, e_wr, e_hi, dn;
    logic [3:0] e_addr;
    logic [1:0] e_fl;
    if (reset) begin
      exp_q.delete();
      m_active = 1'b0;
      m_age = 0;
      m_unitop = 3'b000;
    end else begin
      e_busy = m_active || (exp_q.size() != 0);
      e_stall = e_busy || Start;
      e_mreq = 1'b0; e_freq = 1'b0; e_abort = 1'b0; e_tmo = 1'b0;
      e_wr = 1'b0; e_hi = 1'b0; e_addr = 4'h0; e_fl = 2'b00; dn = 1'b0;
      if (m_active) begin
        dn = m_sel ? FpuDone : MulDone;
        if (m_age == 0) begin e_mreq = !m_sel; e_freq = m_sel; end
        e_tmo = (m_age == T) && !dn;
        e_abort = Kill || e_tmo;
      end
      if (exp_q.size() != 0) begin
        e_wr = 1'b1;
        {e_addr, e_hi, e_fl} = exp_q[0];
      end
      chk("stall_busy", 32'({Stall, Busy}), 32'({e_stall, e_busy}));
      chk("reqs", 32'({MulReq, FpuReq}), 32'({e_mreq, e_freq}));
      chk("abort_timeout", 32'({Abort, Timeout}), 32'({e_abort, e_tmo}));
      chk("writeback", 32'({RegWrEn, WrAddr, WrHi, FlagWEn}), 32'({e_wr, e_addr, e_hi, e_fl}));
      chk("unitop", 32'(UnitOp), 32'(m_unitop));
      chk("dbg_busy", 32'(dbg_state != 3'd0), 32'(e_busy));
      // advance the model to the next cycle
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_active) begin
        if (e_abort) m_active = 1'b0;
        else if (dn) begin
          m_active = 1'b0;
          exp_q.push_back({m_rd, 1'b0, m_fw});
          if (!m_sel && (m_op == 3'b101 || m_op == 3'b110)) exp_q.push_back({m_rdhi, 1'b1, 2'b00});
        end else m_age++;
      end else if (!e_busy && Start && !Kill) begin
        m_active = 1'b1; m_age = 0;
        m_sel = UnitSel; m_op = OpIn; m_fw = FlagWIn; m_rd = RdIn; m_rdhi = RdHiIn;
        m_unitop = OpIn;
      end
    end
  end

  // ---------------- directed driver ----------------
  int r_first_wr, r_wr_cnt, r_stall, r_mreq, r_freq, r_abort, r_tmo, r_tmo_at;
  logic [3:0] r_addr0, r_addr1;
  logic r_hi0, r_hi1, r_end_busy;
  logic [1:0] r_fl0, r_fl1;
  logic [2:0] r_op0;

  // Called just after a rising edge; offset i = 0 is the Start cycle.
  task automatic run_op(input bit sel, input logic [2:0] op, input logic [1:0] fw,
                        input logic [3:0] rd, input logic [3:0] rdhi,
                        input int kill_at, input int spur_at, input int restart_at, input int window);
    r_first_wr = -1; r_wr_cnt = 0; r_stall = 0; r_mreq = 0; r_freq = 0;
    r_abort = 0; r_tmo = 0; r_tmo_at = -1;
    r_addr0 = 4'h0; r_addr1 = 4'h0; r_hi0 = 1'b0; r_hi1 = 1'b0; r_fl0 = 2'b00; r_fl1 = 2'b00;
    r_op0 = 3'b000; r_end_busy = 1'b0;
    UnitSel = sel; OpIn = op; FlagWIn = fw; RdIn = rd; RdHiIn = rdhi;
    Start = 1'b1; Kill = (kill_at == 0);
    for (int i = 0; i < window; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        Start = (i == restart_at);
        Kill = (i == kill_at);
      end
      force_fpu = (i == spur_at);
      @(negedge clk);
      if (Stall) r_stall++;
      if (MulReq) r_mreq++;
      if (FpuReq) r_freq++;
      if (Abort) r_abort++;
      if (Timeout) begin r_tmo++; r_tmo_at = i; end
      if (RegWrEn) begin
        if (r_wr_cnt == 0) begin
          r_first_wr = i; r_addr0 = WrAddr; r_hi0 = WrHi; r_fl0 = FlagWEn; r_op0 = UnitOp;
        end else begin
          r_addr1 = WrAddr; r_hi1 = WrHi; r_fl1 = FlagWEn;
        end
        r_wr_cnt++;
      end
      r_end_busy = Busy;
    end
    @(posedge clk); #1;
    Start = 1'b0; Kill = 1'b0; force_fpu = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'(outs_v), 32'd0);
    @(posedge clk); #1;

    // MUL, done 3 cycles after request
    mul_lat = 3;
    run_op(1'b0, 3'b100, 2'b10, 4'd3, 4'd0, -1, -1, -1, 10);
    chk("mul_latency", r_first_wr, 5);
    chk("mul_wraddr", 32'(r_addr0), 32'd3);
    chk("mul_flags", 32'(r_fl0), 32'b10);
    chk("mul_req_cnt", r_mreq, 1);
    chk("mul_fpureq_cnt", r_freq, 0);
    chk("mul_stall_cycles", r_stall, 6);
    chk("mul_wr_cnt", r_wr_cnt, 1);

    // UMULL, latency 1: two writes
    mul_lat = 1;
    run_op(1'b0, 3'b101, 2'b01, 4'd2, 4'd7, -1, -1, -1, 10);
    chk("umull_latency", r_first_wr, 3);
    chk("umull_wr_cnt", r_wr_cnt, 2);
    chk("umull_lo", 32'({r_addr0, r_hi0, r_fl0}), 32'({4'd2, 1'b0, 2'b01}));
    chk("umull_hi", 32'({r_addr1, r_hi1, r_fl1}), 32'({4'd7, 1'b1, 2'b00}));
    chk("umull_stall_cycles", r_stall, 5);
    chk("umull_idle_after", 32'(r_end_busy), 32'd0);

    // FPU op, done in the request cycle
    fpu_lat = 0;
    run_op(1'b1, 3'b010, 2'b11, 4'd5, 4'd0, -1, -1, -1, 8);
    chk("fpu0_latency", r_first_wr, 2);
    chk("fpu0_reqs", 32'({r_mreq[7:0], r_freq[7:0]}), 32'({8'd0, 8'd1}));
    chk("fpu0_wr", 32'({r_addr0, r_fl0}), 32'({4'd5, 2'b11}));
    chk("fpu0_stall_cycles", r_stall, 3);

    // FPU op that never finishes: watchdog
    fpu_lat = -1;
    run_op(1'b1, 3'b011, 2'b00, 4'd4, 4'd0, -1, -1, -1, 14);
    chk("tmo_count", r_tmo, 1);
    chk("tmo_offset", r_tmo_at, 1 + T);
    chk("tmo_abort_count", r_abort, 1);
    chk("tmo_no_write", r_wr_cnt, 0);
    chk("tmo_stall_cycles", r_stall, T + 2);
    chk("tmo_idle_after", 32'(r_end_busy), 32'd0);

    // Kill coincident with MulDone in WAIT
    mul_lat = 2;
    run_op(1'b0, 3'b100, 2'b11, 4'd8, 4'd0, 3, -1, -1, 8);
    chk("killdone_abort", r_abort, 1);
    chk("killdone_no_write", r_wr_cnt, 0);
    chk("killdone_stall_cycles", r_stall, 4);

    // Kill during WB_LO is ignored
    mul_lat = 0;
    run_op(1'b0, 3'b100, 2'b01, 4'd9, 4'd0, 2, -1, -1, 6);
    chk("killwb_write", 32'({r_wr_cnt[3:0], r_addr0}), 32'({4'd1, 4'd9}));
    chk("killwb_no_abort", r_abort, 0);

    // SMULL with a spurious FpuDone and a Start while busy
    mul_lat = 4;
    run_op(1'b0, 3'b110, 2'b00, 4'd1, 4'd6, -1, 3, 2, 12);
    chk("spur_latency", r_first_wr, 6);
    chk("spur_wr_cnt", r_wr_cnt, 2);
    chk("spur_addrs", 32'({r_addr0, r_addr1}), 32'({4'd1, 4'd6}));
    chk("spur_unitop", 32'(r_op0), 32'b110);
    chk("spur_stall_cycles", r_stall, 8);

    // Reset while waiting
    mul_lat = -1;
    UnitSel = 1'b0; OpIn = 3'b100; FlagWIn = 2'b10; RdIn = 4'd3; Start = 1'b1;
    @(posedge clk); #1 Start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_op", 32'(outs_v), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      Start = ($urandom_range(0, 2) == 0);
      UnitSel = 1'($urandom_range(0, 1));
      OpIn = UnitSel ? 3'($urandom_range(0, 7)) : 3'(3'd4 + 3'($urandom_range(0, 2)));
      FlagWIn = 2'($urandom_range(0, 3));
      RdIn = 4'($urandom_range(0, 15));
      RdHiIn = 4'($urandom_range(0, 15));
      Kill = ($urandom_range(0, 19) == 0);
      mul_lat = int'($urandom_range(0, 11));
      if (mul_lat > 9) mul_lat = -1;
      fpu_lat = int'($urandom_range(0, 11));
      if (fpu_lat > 9) fpu_lat = -1;
      @(posedge clk); #1;
    end
    reset = 1'b0; Start = 1'b0; Kill = 1'b0; spur_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
